// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY receive sequencer: state encoding, word width
// and watchdog limit.
package phy_rx_pkg;

  localparam int WORD_W         = 32;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    WAIT_WORD
  } rx_state_t;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous word FIFO with show-ahead read. A push while full is accepted
// only when a pop happens in the same cycle.
module rx_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Empty reads return zero so rd_data is clean out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_ctrl.sv
// Receive-path sequencer: gates PHY bits into the deserializer, zero-pads the
// last word, buffers words and raises interrupts. Watchdog: RX_CTRL_TIMEOUT_EN.
module phy_rx_ctrl
  import phy_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          frame_len,
  input  logic                          bit_valid,
  input  logic                          bit_in,
  output logic                          des_we,
  output logic                          des_data,
  input  logic                          des_valid,
  input  logic [DATA_WIDTH-1:0]         des_word,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  input  logic                          en_irq,
  input  logic                          clear_irq,
  output logic                          irq,
  output logic                          done_flag,
  output logic                          ovf_flag,
  output logic                          tmo_flag
);

  localparam int PAD_W = $clog2(WORD_W);

  rx_state_t            state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [PAD_W-1:0]     pad;
  logic                 des_valid_q;
  logic                 word_evt;
  logic                 fifo_full;
  logic                 pop_ok;
  logic                 done_set;
  logic                 ovf_set;
  logic                 tmo_set;
  logic                 tmo_empty;
  logic [PAD_W-1:0]     tmo_pad;
  logic                 set_q;

  assign word_evt = des_valid & ~des_valid_q;
  assign pop_ok   = rd_en & ~fifo_empty;
  assign ovf_set  = word_evt & fifo_full & ~pop_ok;
  assign done_set = ((state == WAIT_WORD) && word_evt) || tmo_empty;
  assign busy     = (state != IDLE);

`ifdef RX_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] idle_cnt;
  logic [PAD_W-1:0] word_pos;

  assign tmo_set   = (state == RECV) && !bit_valid &&
                     (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  // A word-aligned timeout has nothing left in the deserializer, so finish at once.
  assign tmo_empty = tmo_set && (word_pos == '0);
  assign tmo_pad   = PAD_W'(0) - word_pos;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      word_pos <= '0;
    end else if (state == IDLE) begin
      idle_cnt <= '0;
      word_pos <= '0;
    end else if (state == RECV) begin
      if (bit_valid) begin
        idle_cnt <= '0;
        word_pos <= word_pos + PAD_W'(1);
      end else if (!tmo_set) begin
        idle_cnt <= idle_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign tmo_set   = 1'b0;
  assign tmo_empty = 1'b0;
  assign tmo_pad   = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      pad       <= '0;
      des_we    <= 1'b0;
      des_data  <= 1'b0;
    end else begin
      des_we   <= 1'b0;
      des_data <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (frame_len != '0)) begin
            remaining <= frame_len;
            pad       <= PAD_W'(0) - frame_len[PAD_W-1:0];
            state     <= RECV;
          end
        end
        RECV: begin
          if (bit_valid) begin
            des_we    <= 1'b1;
            des_data  <= bit_in;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1))
              state <= (pad != '0) ? FLUSH : WAIT_WORD;
          end else if (tmo_set) begin
            pad   <= tmo_pad;
            state <= tmo_empty ? IDLE : FLUSH;
          end
        end
        FLUSH: begin
          des_we <= 1'b1;
          pad    <= pad - PAD_W'(1);
          if (pad == PAD_W'(1))
            state <= WAIT_WORD;
        end
        WAIT_WORD: begin
          if (word_evt)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clear_irq wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      des_valid_q <= 1'b0;
      done_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
      tmo_flag    <= 1'b0;
      set_q       <= 1'b0;
      irq         <= 1'b0;
    end else begin
      des_valid_q <= des_valid;
      done_flag   <= done_set | (done_flag & ~clear_irq);
      ovf_flag    <= ovf_set  | (ovf_flag  & ~clear_irq);
      tmo_flag    <= tmo_set  | (tmo_flag  & ~clear_irq);
      set_q       <= done_set | ovf_set | tmo_set;
      irq         <= (set_q & en_irq) | (irq & ~clear_irq);
    end
  end

  rx_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_evt),
    .push_data (des_word),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_phy_rx_ctrl.sv
// Self-checking bench for phy_rx_ctrl with a behavioural deserializer and a
// word scoreboard. Watchdog scenario runs when RX_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_phy_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] frameLen;
  logic        bitValid;
  logic        bitIn;
  logic        desWe;
  logic        desData;
  logic        desValid;
  logic [31:0] desWord;
  logic        rdEn;
  logic [31:0] rdData;
  logic        fifoEmpty;
  logic [2:0]  fifoLevel;
  logic        busy;
  logic        enIrq;
  logic        clearIrq;
  logic        irq;
  logic        doneFlag;
  logic        ovfFlag;
  logic        tmoFlag;

  int          totalCount = 0;
  int          badCount   = 0;
  int          weCount    = 0;
  int          wordsOut;
  logic [4:0]  desCnt;
  logic [31:0] desShift;
  logic        bitQ[$];
  logic [31:0] expQ[$];

  phy_rx_ctrl #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .LEN_WIDTH  (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_len  (frameLen),
    .bit_valid  (bitValid),
    .bit_in     (bitIn),
    .des_we     (desWe),
    .des_data   (desData),
    .des_valid  (desValid),
    .des_word   (desWord),
    .rd_en      (rdEn),
    .rd_data    (rdData),
    .fifo_empty (fifoEmpty),
    .fifo_level (fifoLevel),
    .busy       (busy),
    .en_irq     (enIrq),
    .clear_irq  (clearIrq),
    .irq        (irq),
    .done_flag  (doneFlag),
    .ovf_flag   (ovfFlag),
    .tmo_flag   (tmoFlag)
  );

  always #5 clk = ~clk;

  // Deserializer stand-in: shifts LSB first, pulses desValid for one cycle per word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      desCnt   <= '0;
      desShift <= '0;
      desValid <= 1'b0;
      desWord  <= '0;
      wordsOut <= 0;
    end else begin
      desValid <= 1'b0;
      if (desWe) begin
        desShift[desCnt] <= desData;
        desCnt           <= desCnt + 5'd1;
        if (desCnt == 5'd31) begin
          desWord  <= {desData, desShift[30:0]};
          desValid <= 1'b1;
          wordsOut <= wordsOut + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (desWe)
      weCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got=running expected=finished");
    $fatal(1, "[TB] simulation time bound exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic loadWord(input logic [31:0] w, input int n);
    for (int j = 0; j < n; j++)
      bitQ.push_back(w[j]);
  endtask

  // Drives a start then every queued bit back to back; expected words go to the scoreboard.
  task automatic applyStimulus(input int len, input bit midStart);
    int          nb;
    logic [31:0] w;
    nb = bitQ.size();
    for (int i = 0; i < nb; i += 32) begin
      w = '0;
      for (int j = 0; j < 32 && (i + j) < nb; j++)
        w[j] = bitQ[i + j];
      expQ.push_back(w);
    end
    @(negedge clk);
    start    = 1'b1;
    frameLen = 12'(len);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    for (int k = 0; k < nb; k++) begin
      bitValid = 1'b1;
      bitIn    = bitQ[k];
      if (midStart && k == 20) begin
        start    = 1'b1;
        frameLen = 12'd5;
      end
      @(negedge clk);
      start = 1'b0;
    end
    bitValid = 1'b0;
    bitIn    = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int cyc = 0;
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("idle_reached", busy, 0);
  endtask

  task automatic waitWord(input int target, input string tag);
    int cyc = 0;
    while (!(desValid && wordsOut == target) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(tag, 32'(desValid && wordsOut == target), 1);
  endtask

  task automatic drainFifo(input int n);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      checkOutput("fifo_not_empty", fifoEmpty, 0);
      exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hDEAD_DEAD;
      checkOutput("rd_data", rdData, exp);
      rdEn = 1'b1;
      @(negedge clk);
      rdEn = 1'b0;
    end
    checkOutput("fifo_empty_after_drain", fifoEmpty, 1);
  endtask

  task automatic clearFlags();
    @(negedge clk);
    clearIrq = 1'b1;
    @(negedge clk);
    clearIrq = 1'b0;
  endtask

  initial begin
    int weBase;
    int wordBase;
    reset    = 1'b0;
    start    = 1'b0;
    frameLen = '0;
    bitValid = 1'b0;
    bitIn    = 1'b0;
    rdEn     = 1'b0;
    enIrq    = 1'b1;
    clearIrq = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fifo_empty", fifoEmpty, 1);
    checkOutput("rst_fifo_level", fifoLevel, 0);
    checkOutput("rst_irq", irq, 0);
    checkOutput("rst_des_we", desWe, 0);
    checkOutput("rst_flags", {doneFlag, ovfFlag, tmoFlag}, 0);
    checkOutput("rst_rd_data", rdData, 0);
    reset = 1'b1;
    @(negedge clk);

    // Two aligned words with an ignored start mid-frame.
    $display("[TB] aligned 64-bit frame");
    weBase = weCount;
    bitQ.delete();
    loadWord(32'hA5A5_A5A5, 32);
    loadWord(32'h1234_5678, 32);
    applyStimulus(64, 1'b1);
    waitIdle(100);
    checkOutput("t1_done", doneFlag, 1);
    checkOutput("t1_we_pulses", weCount - weBase, 64);
    checkOutput("t1_level", fifoLevel, 2);
    checkOutput("t1_tmo", tmoFlag, 0);
    @(negedge clk);
    checkOutput("t1_irq", irq, 1);
    drainFifo(2);
    clearFlags();
    checkOutput("t1_cleared", {irq, doneFlag, ovfFlag, tmoFlag}, 0);

    // Partial final word: 8 data bits plus 24 pad bits.
    $display("[TB] 40-bit frame with padding");
    weBase = weCount;
    bitQ.delete();
    loadWord(32'hDEAD_BEEF, 32);
    loadWord(32'hFFFF_FFFF, 8);
    applyStimulus(40, 1'b0);
    waitIdle(100);
    checkOutput("t2_done", doneFlag, 1);
    checkOutput("t2_we_pulses", weCount - weBase, 64);
    drainFifo(2);
    rdEn = 1'b1;
    @(negedge clk);
    rdEn = 1'b0;
    checkOutput("t2_pop_empty_level", fifoLevel, 0);
    checkOutput("t2_pop_empty_flag", fifoEmpty, 1);
    clearFlags();

    // Six words into a 4-deep FIFO; a pop rescues the fifth push.
    $display("[TB] overflow frame");
    bitQ.delete();
    for (int i = 0; i < 6; i++)
      loadWord(32'hC0DE_0000 | 32'(i * 17 + 3), 32);
    wordBase = wordsOut;
    fork
      applyStimulus(192, 1'b0);
      begin
        waitWord(wordBase + 5, "t3_word5_seen");
        rdEn = 1'b1;
        checkOutput("t3_pop_on_full", rdData, expQ[0]);
        void'(expQ.pop_front());
        @(negedge clk);
        rdEn = 1'b0;
        checkOutput("t3_no_ovf_with_pop", ovfFlag, 0);
        checkOutput("t3_level_pop_push", fifoLevel, 4);
      end
    join
    waitIdle(100);
    checkOutput("t3_ovf", ovfFlag, 1);
    checkOutput("t3_done", doneFlag, 1);
    checkOutput("t3_level_full", fifoLevel, 4);
    void'(expQ.pop_back());
    drainFifo(4);
    clearFlags();

    // Start with zero length must not arm a frame.
    $display("[TB] zero-length start");
    weBase = weCount;
    @(negedge clk);
    start    = 1'b1;
    frameLen = 12'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t4_busy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("t4_no_we", weCount - weBase, 0);

    // clear_irq coinciding with the final word event loses to the set.
    $display("[TB] clear versus set");
    bitQ.delete();
    loadWord(32'hCAFE_F00D, 32);
    wordBase = wordsOut;
    fork
      applyStimulus(32, 1'b0);
      begin
        waitWord(wordBase + 1, "t5_word_seen");
        clearIrq = 1'b1;
        @(negedge clk);
        clearIrq = 1'b0;
        checkOutput("t5_done_kept", doneFlag, 1);
        @(negedge clk);
        checkOutput("t5_irq_kept", irq, 1);
      end
    join
    waitIdle(100);
    drainFifo(1);
    clearFlags();
    checkOutput("t5_all_clear", {irq, doneFlag, ovfFlag, tmoFlag}, 0);

`ifdef RX_CTRL_TIMEOUT_EN
    // Frame stalls after 10 bits; watchdog pads out the word.
    $display("[TB] watchdog frame");
    weBase = weCount;
    bitQ.delete();
    loadWord(32'h0000_02B5, 10);
    applyStimulus(64, 1'b0);
    waitIdle(1300);
    checkOutput("t6_tmo", tmoFlag, 1);
    checkOutput("t6_done", doneFlag, 1);
    checkOutput("t6_we_pulses", weCount - weBase, 32);
    checkOutput("t6_level", fifoLevel, 1);
    drainFifo(1);
    clearFlags();
`endif

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/phy_rx_ctrl.md
# phy_rx_ctrl

Receive-path sequencer for the Wi-Fi PHY. It gates the PHY's serial bit stream into the 32-bit RX deserializer and counts bits against a programmed frame length. When a frame ends on a partial word, it pads with zero bits so the final word completes. Completed words go into a small read FIFO for the AHB register block, and the block raises done/overflow interrupts.

## Interface
Parameters:
- DATA_WIDTH, 32, deserializer word width; must be 32
- FIFO_DEPTH, 4, read FIFO entries; power of 2, ≥2
- LEN_WIDTH, 12, frame length counter width in bits

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms a frame receive
- frame_len  in  LEN_WIDTH  payload length in bits; latched on accepted start
- bit_valid  in  1  PHY bit strobe
- bit_in  in  1  PHY serial bit, qualified by bit_valid
- des_we  out  1  deserializer write enable
- des_data  out  1  deserializer serial bit
- des_valid  in  1  deserializer word-valid
- des_word  in  DATA_WIDTH  deserializer word
- rd_en  in  1  FIFO pop request
- rd_data  out  DATA_WIDTH  FIFO head, show-ahead
- fifo_empty  out  1  FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy  out  1  state ≠ IDLE
- en_irq  in  1  interrupt enable
- clear_irq  in  1  clears irq and sticky flags
- irq  out  1  interrupt, registered
- done_flag / ovf_flag / tmo_flag  out  1 each  sticky status

## Operation
- States: IDLE, RECV, FLUSH, WAIT_WORD.
- IDLE:
  - start with frame_len≠0: latch remaining=frame_len and pad=(32−frame_len[4:0]) mod 32, then go to RECV.
  - start with frame_len=0: ignored.
  - start outside IDLE: ignored.
- RECV:
  - Each bit_valid: des_we=1, des_data=bit_in, remaining−1.
  - On the last bit: go to FLUSH if pad≠0, else WAIT_WORD.
  - bit_valid=0: des_we=0.
- FLUSH: des_we=1, des_data=0 every cycle, pad−1; when pad reaches 0, go to WAIT_WORD.
- WAIT_WORD: on the next word event, push the word, set done_flag, go to IDLE.
- Word event: rising edge of des_valid (registered previous value). Words are pushed in every state; des_valid held high does not repush.
- FIFO push when full:
  - Word dropped, ovf_flag set.
  - Exception: if rd_en with not-empty in the same cycle, pop first and no overflow.
- rd_en when empty: ignored.
- irq is set the cycle after done_flag/ovf_flag/tmo_flag rises, if en_irq=1.
- clear_irq clears irq and all sticky flags. A simultaneous set wins over clear.

## Timing
- All outputs reset to 0, FIFO is empty (fifo_empty=1), state=IDLE.
- start → busy high next cycle.
- des_we/des_data are registered: one cycle after bit_valid.
- N-bit frame: exactly 32·⌈N/32⌉ des_we pulses.
- done_flag asserts 1 cycle after the final word event; irq follows 1 cycle later.
- Asserting reset mid-frame aborts immediately. The deserializer shares reset, so no partial word survives.

## Configuration
- RX_CTRL_TIMEOUT_EN defined:
  - A watchdog counts RECV cycles without bit_valid.
  - At 1024 idle cycles: set tmo_flag, go to FLUSH, padding the current word to completion (remaining is discarded).
  - Then WAIT_WORD as normal; done_flag is still set.
  - The counter restarts on every bit_valid.
- Undefined: no watchdog, tmo_flag tied 0, RECV waits indefinitely.

## Structure
- Shared package phy_rx_pkg holds:
  - state encoding typedef
  - word width constant 32
  - timeout constant 1024
- Sub-module rx_word_fifo: parameterized sync FIFO with show-ahead read, push/pop/full/empty/level.

## Test plan
- frame_len=64, 64 continuous bit_valid of pattern 0xA5A5_A5A5, 0x1234_5678 → two words in FIFO in order, no FLUSH, done_flag=1, irq=1 with en_irq=1.
- frame_len=40, bits 0xDEAD_BEEF then 8 bits 0xFF → 8 data + 24 pad des_we pulses; second word 0x0000_00FF (LSB first); done_flag=1.
- FIFO_DEPTH=4, 6-word frame, no reads → first 4 words kept, ovf_flag=1; rd_en on the cycle of the 5th push → no overflow for that word.
- start during RECV and start with frame_len=0 → ignored, busy unchanged, no des_we.
- clear_irq on the same cycle done_flag sets → done_flag and irq remain set; later clear_irq alone → all flags 0.
- (RX_CTRL_TIMEOUT_EN) frame_len=64, stop after 10 bits → after 1024 idle cycles tmo_flag=1, 22 pad bits, one word pushed, done_flag=1.
